// File: rtl/uio_prbs_gen_chk.sv
// PRBS31 word generator toward a user-IO request port plus a self-synchronising PRBS checker on the response port.
// Latency: request word registered one cycle after enable; counters and lock state update one cycle after rs_vld.
// Backpressure: uio_rq_afull stalls the generator without skipping or repeating words; the response side never stalls (uio_rs_afull = 0).
//
// Ports:
//   clk_per, reset_per_n     - clock, asynchronous active-low reset
//   i_enable, i_clr_cnt      - generator run enable, synchronous clear of counters and lock state
//   uio_rq_vld/data/afull    - request word stream and its almost-full backpressure
//   uio_rs_vld/data/afull    - looped-back response stream (afull tied low)
//   o_tx_cnt, o_rx_cnt       - 48-bit wrapping word counters
//   o_err_cnt, o_locked      - saturating bit-error count while locked, lock status
// Optional: define UIO_PRBS_ERR_INJ_EN to add i_inj_err (rising edge flips bit 0 of the next sent word).
module uio_prbs_gen_chk #(
  parameter int UIO_PORTS_WIDTH = 128,
  parameter int ERR_CNT_WIDTH   = 32
) (
  input  logic                       clk_per,
  input  logic                       reset_per_n,
  input  logic                       i_enable,
  input  logic                       i_clr_cnt,
`ifdef UIO_PRBS_ERR_INJ_EN
  input  logic                       i_inj_err,
`endif
  output logic                       uio_rq_vld,
  output logic [UIO_PORTS_WIDTH-1:0] uio_rq_data,
  input  logic                       uio_rq_afull,
  input  logic                       uio_rs_vld,
  input  logic [UIO_PORTS_WIDTH-1:0] uio_rs_data,
  output logic                       uio_rs_afull,
  output logic [47:0]                o_tx_cnt,
  output logic [47:0]                o_rx_cnt,
  output logic [ERR_CNT_WIDTH-1:0]   o_err_cnt,
  output logic                       o_locked
);

  localparam int W  = UIO_PORTS_WIDTH;
  localparam int EW = ERR_CNT_WIDTH;
  localparam int MW = $clog2(W + 1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  // Extend the 31-bit history (bit 0 earliest) by W bits of b[n]=b[n-31]^b[n-28].
  function automatic logic [W-1:0] prbs_word(input logic [30:0] hist);
    logic [W+30:0] ext;
    ext        = '0;
    ext[30:0]  = hist;
    for (int j = 0; j < W; j++) begin
      ext[31+j] = ext[j] ^ ext[j+3];
    end
    return ext[W+30:31];
  endfunction

  function automatic logic [MW-1:0] popcnt(input logic [W-1:0] v);
    logic [MW-1:0] cnt;
    cnt = '0;
    for (int j = 0; j < W; j++) begin
      cnt = cnt + {{(MW-1){1'b0}}, v[j]};
    end
    return cnt;
  endfunction

  // Generator state
  logic [30:0]   gen_state_q, gen_state_d;
  logic          rq_vld_q, rq_vld_d;
  logic [W-1:0]  rq_data_q, rq_data_d;
  logic [47:0]   tx_cnt_q, tx_cnt_d;
  logic [W-1:0]  tx_word;
  logic          tx_fire;
  logic          inj_flip;

  // Checker state
  lock_state_t   state_q, state_d;
  logic [1:0]    good_cnt_q, good_cnt_d;
  logic [2:0]    bad_cnt_q, bad_cnt_d;
  logic          hist_vld_q, hist_vld_d;
  logic [30:0]   rx_hist_q, rx_hist_d;
  logic [47:0]   rx_cnt_q, rx_cnt_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [W-1:0]  exp_word;
  logic [MW-1:0] mismatch;
  logic [EW:0]   err_sum;

`ifdef UIO_PRBS_ERR_INJ_EN
  logic inj_prev_q, inj_prev_d;
  logic inj_pend_q, inj_pend_d;

  // A rising edge arms a one-shot flip that is consumed by the next sent word,
  // including a word sent in the very cycle of the edge.
  always_comb begin
    inj_prev_d = i_inj_err;
    inj_flip   = inj_pend_q | (i_inj_err & ~inj_prev_q);
    inj_pend_d = tx_fire ? 1'b0 : inj_flip;
  end

  always_ff @(posedge clk_per or negedge reset_per_n) begin
    if (!reset_per_n) begin
      inj_prev_q <= 1'b0;
      inj_pend_q <= 1'b0;
    end else begin
      inj_prev_q <= inj_prev_d;
      inj_pend_q <= inj_pend_d;
    end
  end
`else
  assign inj_flip = 1'b0;
`endif

  // Generator: state only advances when a word is actually sent, so stalls are lossless.
  always_comb begin
    gen_state_d = gen_state_q;
    rq_vld_d    = 1'b0;
    rq_data_d   = rq_data_q;
    tx_cnt_d    = tx_cnt_q;
    tx_word     = prbs_word(gen_state_q);
    tx_fire     = i_enable & ~uio_rq_afull;
    if (tx_fire) begin
      rq_vld_d    = 1'b1;
      rq_data_d   = tx_word ^ {{(W-1){1'b0}}, inj_flip};
      gen_state_d = tx_word[W-1 -: 31];
      tx_cnt_d    = tx_cnt_q + 48'd1;
    end
    if (i_clr_cnt) begin
      tx_cnt_d = '0;
    end
  end

  // Checker: expectation is rebuilt from each received word, so it self-synchronises.
  always_comb begin
    exp_word   = prbs_word(rx_hist_q);
    mismatch   = popcnt(exp_word ^ uio_rs_data);
    err_sum    = {1'b0, err_cnt_q} + (EW+1)'(mismatch);
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    hist_vld_d = hist_vld_q;
    rx_hist_d  = rx_hist_q;
    rx_cnt_d   = rx_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (i_clr_cnt) begin
      state_d    = ST_UNLOCKED;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      hist_vld_d = 1'b0;
      rx_cnt_d   = '0;
      err_cnt_d  = '0;
    end else if (uio_rs_vld) begin
      rx_cnt_d   = rx_cnt_q + 48'd1;
      hist_vld_d = 1'b1;
      rx_hist_d  = uio_rs_data[W-1 -: 31];
      // The first word after reset/clear only seeds the history.
      if (hist_vld_q) begin
        if (state_q == ST_LOCKED) begin
          err_cnt_d = err_sum[EW] ? {EW{1'b1}} : err_sum[EW-1:0];
        end
        case (state_q)
          ST_UNLOCKED: begin
            if (mismatch == '0) begin
              if (good_cnt_q == 2'd3) begin
                state_d    = ST_LOCKED;
                good_cnt_d = '0;
              end else begin
                good_cnt_d = good_cnt_q + 2'd1;
              end
            end else begin
              good_cnt_d = '0;
            end
          end
          default: begin
            if (mismatch != '0) begin
              if (bad_cnt_q == 3'd7) begin
                state_d   = ST_UNLOCKED;
                bad_cnt_d = '0;
              end else begin
                bad_cnt_d = bad_cnt_q + 3'd1;
              end
            end else begin
              bad_cnt_d = '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_per or negedge reset_per_n) begin
    if (!reset_per_n) begin
      gen_state_q <= 31'h7FFF_FFFF;
      rq_vld_q    <= 1'b0;
      rq_data_q   <= '0;
      tx_cnt_q    <= '0;
      state_q     <= ST_UNLOCKED;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      hist_vld_q  <= 1'b0;
      rx_hist_q   <= '0;
      rx_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      gen_state_q <= gen_state_d;
      rq_vld_q    <= rq_vld_d;
      rq_data_q   <= rq_data_d;
      tx_cnt_q    <= tx_cnt_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      hist_vld_q  <= hist_vld_d;
      rx_hist_q   <= rx_hist_d;
      rx_cnt_q    <= rx_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign uio_rq_vld   = rq_vld_q;
  assign uio_rq_data  = rq_data_q;
  assign uio_rs_afull = 1'b0;
  assign o_tx_cnt     = tx_cnt_q;
  assign o_rx_cnt     = rx_cnt_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_uio_prbs_gen_chk.sv
// Directed-plus-random bench for uio_prbs_gen_chk: loopback, stall, bit flips, random garbage, clear, reset.
// Reference model works on a bit queue and counts runs of clean/bad words directly.
// Optional injection checks run when UIO_PRBS_ERR_INJ_EN is defined.
module tb_uio_prbs_gen_chk;

  localparam int W  = 128;
  localparam int EW = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk_per;
  logic          reset_per_n;
  logic          i_enable;
  logic          i_clr_cnt;
  logic          i_inj_err;
  logic          uio_rq_vld;
  logic [W-1:0]  uio_rq_data;
  logic          uio_rq_afull;
  logic          uio_rs_vld;
  logic [W-1:0]  uio_rs_data;
  logic          uio_rs_afull;
  logic [47:0]   o_tx_cnt;
  logic [47:0]   o_rx_cnt;
  logic [EW-1:0] o_err_cnt;
  logic          o_locked;

  uio_prbs_gen_chk #(.UIO_PORTS_WIDTH(W), .ERR_CNT_WIDTH(EW)) dut (
    .clk_per      (clk_per),
    .reset_per_n  (reset_per_n),
    .i_enable     (i_enable),
    .i_clr_cnt    (i_clr_cnt),
`ifdef UIO_PRBS_ERR_INJ_EN
    .i_inj_err    (i_inj_err),
`endif
    .uio_rq_vld   (uio_rq_vld),
    .uio_rq_data  (uio_rq_data),
    .uio_rq_afull (uio_rq_afull),
    .uio_rs_vld   (uio_rs_vld),
    .uio_rs_data  (uio_rs_data),
    .uio_rs_afull (uio_rs_afull),
    .o_tx_cnt     (o_tx_cnt),
    .o_rx_cnt     (o_rx_cnt),
    .o_err_cnt    (o_err_cnt),
    .o_locked     (o_locked)
  );

  initial begin
    clk_per = 1'b0;
    forever #5 clk_per = ~clk_per;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [30:0]  m_gen;
  logic         m_rq_vld;
  logic [W-1:0] m_rq_data;
  logic [W-1:0] m_clean;
  logic [47:0]  m_tx;
  logic [47:0]  m_rx;
  int           m_err;
  bit           m_locked;
  int           m_good;
  int           m_bad;
  bit           m_hist_vld;
  logic [30:0]  m_hist;
  bit           m_inj_prev;
  bit           m_inj_pend;

  bit           loop_en;
  logic [W-1:0] flip_mask;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PRBS31 continuation as a literal bit stream: oldest bit first.
  function automatic logic [W-1:0] ref_word(input logic [30:0] last31);
    bit s[$];
    logic [W-1:0] w;
    for (int i = 0; i < 31; i++) s.push_back(last31[i]);
    for (int j = 0; j < W; j++) begin
      w[j] = s[s.size()-31] ^ s[s.size()-28];
      s.push_back(w[j]);
    end
    return w;
  endfunction

  task automatic model_reset();
    m_gen      = 31'h7FFF_FFFF;
    m_rq_vld   = 1'b0;
    m_rq_data  = '0;
    m_clean    = '0;
    m_tx       = '0;
    m_rx       = '0;
    m_err      = 0;
    m_locked   = 1'b0;
    m_good     = 0;
    m_bad      = 0;
    m_hist_vld = 1'b0;
    m_hist     = '0;
    m_inj_prev = 1'b0;
    m_inj_pend = 1'b0;
  endtask

  // Apply the current inputs to the model as the next clock edge would.
  task automatic model_edge();
    bit fire;
    bit inj_now;
    int mm;
    logic [W-1:0] w;
    fire    = i_enable && !uio_rq_afull;
    inj_now = 1'b0;
`ifdef UIO_PRBS_ERR_INJ_EN
    inj_now    = m_inj_pend || (i_inj_err && !m_inj_prev);
    m_inj_prev = i_inj_err;
    m_inj_pend = fire ? 1'b0 : inj_now;
`endif
    m_rq_vld = fire;
    if (fire) begin
      w         = ref_word(m_gen);
      m_clean   = w;
      m_rq_data = w ^ W'(inj_now);
      m_gen     = w[W-1:W-31];
      m_tx      = m_tx + 48'd1;
    end
    if (i_clr_cnt) begin
      m_tx = '0; m_rx = '0; m_err = 0; m_locked = 1'b0;
      m_good = 0; m_bad = 0; m_hist_vld = 1'b0;
    end else if (uio_rs_vld) begin
      m_rx = m_rx + 48'd1;
      if (m_hist_vld) begin
        w  = ref_word(m_hist);
        mm = $countones(w ^ uio_rs_data);
        if (m_locked) m_err = (m_err + mm > ERR_MAX) ? ERR_MAX : m_err + mm;
        if (mm == 0) begin
          m_bad = 0;
          if (!m_locked) begin
            m_good++;
            if (m_good == 4) begin m_locked = 1'b1; m_good = 0; end
          end
        end else begin
          m_good = 0;
          if (m_locked) begin
            m_bad++;
            if (m_bad == 8) begin m_locked = 1'b0; m_bad = 0; end
          end
        end
      end
      m_hist_vld = 1'b1;
      m_hist     = uio_rs_data[W-1:W-31];
    end
  endtask

  task automatic check_all();
    chk("rq_vld", W'(uio_rq_vld), W'(m_rq_vld));
    if (m_rq_vld) chk("rq_data", uio_rq_data, m_rq_data);
    chk("tx_cnt", W'(o_tx_cnt), W'(m_tx));
    chk("rx_cnt", W'(o_rx_cnt), W'(m_rx));
    chk("err_cnt", W'(o_err_cnt), W'(m_err));
    chk("locked", W'(o_locked), W'(m_locked));
    chk("rs_afull", W'(uio_rs_afull), '0);
  endtask

  // One clock: optional loopback of the current request word, then check after the edge.
  task automatic step();
    if (loop_en) begin
      uio_rs_vld  = uio_rq_vld;
      uio_rs_data = uio_rq_data ^ flip_mask;
    end
    model_edge();
    @(posedge clk_per);
    #1;
    check_all();
  endtask

  initial begin
    logic [47:0] r0;
`ifdef UIO_PRBS_ERR_INJ_EN
    int flips;
    logic [W-1:0] d;
`endif
    reset_per_n  = 1'b1;
    i_enable     = 1'b0;
    i_clr_cnt    = 1'b0;
    i_inj_err    = 1'b0;
    uio_rq_afull = 1'b0;
    uio_rs_vld   = 1'b0;
    uio_rs_data  = '0;
    loop_en      = 1'b0;
    flip_mask    = '0;
    model_reset();

    // Reset state
    #3 reset_per_n = 1'b0;
    @(posedge clk_per); @(posedge clk_per); #1;
    check_all();
    chk("rst_rq_data", uio_rq_data, '0);
    reset_per_n = 1'b1;

    // First word and 100-word loopback
    i_enable = 1'b1;
    loop_en  = 1'b1;
    step();
    chk("first_word", W'(uio_rq_data[30:0]), W'(31'h7000_0000));
    chk("first_tx_cnt", W'(o_tx_cnt), W'(1));
    for (int i = 1; i < 100; i++) begin
      step();
      if (m_rx == 48'd6) chk("lock_by_6", W'(o_locked), W'(1));
    end
    i_enable = 1'b0;
    step();
    step();
    chk("lb_rx_100", W'(o_rx_cnt), W'(100));
    chk("lb_err_0", W'(o_err_cnt), '0);
    chk("lb_locked", W'(o_locked), W'(1));

    // Stall mid-stream
    i_enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    uio_rq_afull = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_novld", W'(uio_rq_vld), '0);
    end
    uio_rq_afull = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("stall_locked", W'(o_locked), W'(1));
    chk("stall_err_0", W'(o_err_cnt), '0);

    // Three-bit corruption while locked
    flip_mask = '0;
    flip_mask[5] = 1'b1; flip_mask[60] = 1'b1; flip_mask[100] = 1'b1;
    step();
    flip_mask = '0;
    for (int i = 0; i < 20; i++) step();
    chk("flip_err_ge3", W'(o_err_cnt >= EW'(3)), W'(1));
    chk("flip_locked", W'(o_locked), W'(1));

    // Eight random words while locked, then relock on clean PRBS
    i_enable = 1'b0;
    step();
    loop_en  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      uio_rs_vld  = 1'b1;
      uio_rs_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    chk("rand_unlocked", W'(o_locked), '0);
    chk("rand_err_sat", W'(o_err_cnt), W'(ERR_MAX));
    uio_rs_vld = 1'b0;
    step();
    r0 = m_rx;
    loop_en  = 1'b1;
    i_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_rx == r0 + 48'd4) chk("relock_not_yet", W'(o_locked), '0);
      if (m_rx == r0 + 48'd5) chk("relock_4_clean", W'(o_locked), W'(1));
    end

    // Clear together with rs_vld
    i_clr_cnt = 1'b1;
    step();
    i_clr_cnt = 1'b0;
    chk("clr_tx", W'(o_tx_cnt), '0);
    chk("clr_rx", W'(o_rx_cnt), '0);
    chk("clr_err", W'(o_err_cnt), '0);
    chk("clr_locked", W'(o_locked), '0);
    for (int i = 0; i < 8; i++) step();

    // Asynchronous reset mid-stream, then restart from word 0
    reset_per_n = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("arst_rq_data", uio_rq_data, '0);
    @(posedge clk_per); #1;
    reset_per_n = 1'b1;
    step();
    chk("restart_word", W'(uio_rq_data[30:0]), W'(31'h7000_0000));
    chk("restart_tx", W'(o_tx_cnt), W'(1));
    for (int i = 0; i < 8; i++) step();

`ifdef UIO_PRBS_ERR_INJ_EN
    // One injection pulse: exactly one word with bit 0 inverted
    loop_en    = 1'b0;
    uio_rs_vld = 1'b0;
    flips      = 0;
    for (int i = 0; i < 8; i++) begin
      i_inj_err = (i == 2 || i == 3);
      step();
      d = uio_rq_data ^ m_clean;
      if (uio_rq_vld && d != '0) begin
        flips++;
        chk("inj_bit0", d, W'(1));
      end
    end
    chk("inj_once", W'(flips), W'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
